spi_flash_arbiter: RTL and testbench

Two-requester arbiter in front of MappedSPIFlash, sharing the single memory-mapped SPI flash read port between instruction fetch (port 0) and data loads (port 1). Each port keeps the MappedSPIFlash handshake (rstrb pulse, word_address, rdata, rbusy). The arbiter latches pulsed requests, grants round-robin and sequences one flash word read at a time. A timeout watchdog catches a flash that never releases busy.

---
 rtl/spi_flash_arb_pkg.sv | 13 +
 rtl/spi_flash_arb_port.sv | 61 ++++++
 rtl/spi_flash_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_arb_pkg.sv
// Shared types and defaults for the two-port SPI flash read arbiter.
package spi_flash_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} arb_state_e;

  localparam int ADDR_W_DEF  = 20;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 4096;

  // Returned to the requester when the flash never releases busy (DATA_W up to 64).
  localparam logic [63:0] TMO_DATA = '1;

endpackage

// File: rtl/spi_flash_arb_port.sv
// One requester-side slot: captures a pulsed read request, holds its address
// and returned word, and reports busy back in the MappedSPIFlash handshake style.
module spi_flash_arb_port #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rstrb_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              served_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rbusy_o
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;

  // A strobe is only taken when nothing is outstanding for this port.
  assign accept = rstrb_i & ~pend_q & ~served_i;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    if (accept) begin
      pend_d = 1'b1;
      addr_d = addr_i;
    end
    if (wr_i) begin
      pend_d  = 1'b0;
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign rdata_o = rdata_q;
  assign rbusy_o = ~reset & (rstrb_i | pend_q | served_i);

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one MappedSPIFlash read port between two requesters,
// with a busy watchdog. Optional last-word cache: SPI_ARB_LASTWORD_CACHE_EN.
module spi_flash_arbiter
  import spi_flash_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rstrb_0,
  input  logic [ADDR_W-1:0] word_address_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              rbusy_0,
  input  logic              rstrb_1,
  input  logic [ADDR_W-1:0] word_address_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rbusy_1,
  output logic              f_rstrb,
  output logic [ADDR_W-1:0] f_word_address,
  input  logic [DATA_W-1:0] f_rdata,
  input  logic              f_rbusy,
  output logic              err
);

  localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic              WD_EN    = (TIMEOUT != 0);
  localparam logic [DATA_W-1:0] TMO_WORD = TMO_DATA[DATA_W-1:0];

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend0, pend1, any_pend, sel, hit, done, tmo, finish;
  logic              served0, served1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1, sel_addr;
  logic [DATA_W-1:0] wdata;

  spi_flash_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
    .clk(clk), .reset(reset), .rstrb_i(rstrb_0), .addr_i(word_address_0),
    .served_i(served0), .wr_i(wr0), .wdata_i(wdata),
    .pend_o(pend0), .addr_o(addr0), .rdata_o(rdata_0), .rbusy_o(rbusy_0)
  );

  spi_flash_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clk(clk), .reset(reset), .rstrb_i(rstrb_1), .addr_i(word_address_1),
    .served_i(served1), .wr_i(wr1), .wdata_i(wdata),
    .pend_o(pend1), .addr_o(addr1), .rdata_o(rdata_1), .rbusy_o(rbusy_1)
  );

  // With both pending, the port that was not served last wins.
  assign any_pend = pend0 | pend1;
  assign sel      = (pend0 & pend1) ? ~last_q : pend1;
  assign sel_addr = sel ? addr1 : addr0;
  assign done     = (state_q == WAIT) & ~f_rbusy;
  assign tmo      = (state_q == WAIT) & f_rbusy & WD_EN & (cnt_q == CNT_LAST);
  assign finish   = done | tmo;

`ifdef SPI_ARB_LASTWORD_CACHE_EN
  logic              cvld_q;
  logic [ADDR_W-1:0] caddr_q;
  logic [DATA_W-1:0] cdata_q;

  assign hit = (state_q == IDLE) & any_pend & cvld_q & (caddr_q == sel_addr);

  always_ff @(posedge clk) begin
    if (reset || tmo) cvld_q <= 1'b0;
    else if (done)    cvld_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (done) begin
      caddr_q <= faddr_q;
      cdata_q <= f_rdata;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_pend && !hit) state_d = ISSUE;
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = WAIT;
      WAIT:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    f_rstrb = (state_q == ISSUE);
    served0 = (state_q != IDLE) & ~grant_q;
    served1 = (state_q != IDLE) & grant_q;
    wr0     = (finish & ~grant_q) | (hit & ~sel);
    wr1     = (finish & grant_q) | (hit & sel);
    wdata   = tmo ? TMO_WORD : f_rdata;
`ifdef SPI_ARB_LASTWORD_CACHE_EN
    if (hit) wdata = cdata_q;
`endif
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    faddr_d = faddr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (any_pend) begin
        grant_d = sel;
        if (hit) last_d  = sel;
        else     faddr_d = sel_addr;
      end
      GUARD: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (finish) last_d = grant_q;
        if (tmo)    err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      faddr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      faddr_q <= faddr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign f_word_address = faddr_q;
  assign err            = err_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter against a small MappedSPIFlash model.
module tb_spi_flash_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rstrb_0 = 1'b0, rstrb_1 = 1'b0;
  logic [19:0] wa0 = '0, wa1 = '0;
  logic [31:0] rdata_0, rdata_1;
  logic        rbusy_0, rbusy_1;
  logic        f_rstrb;
  logic [19:0] f_word_address;
  logic [31:0] f_rdata;
  logic        f_rbusy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .rstrb_0(rstrb_0), .word_address_0(wa0), .rdata_0(rdata_0), .rbusy_0(rbusy_0),
    .rstrb_1(rstrb_1), .word_address_1(wa1), .rdata_1(rdata_1), .rbusy_1(rbusy_1),
    .f_rstrb(f_rstrb), .f_word_address(f_word_address),
    .f_rdata(f_rdata), .f_rbusy(f_rbusy), .err(err)
  );

  function automatic logic [31:0] word_of(input logic [19:0] a);
    return (a == 20'd5) ? 32'hDEADBEEF : (32'hC0DE0000 | {12'h000, a});
  endfunction

  // Flash model: busy for a few cycles after each strobe, or forever while stuck.
  logic        fbusy;
  int          fcnt;
  logic [19:0] faddr;
  logic        stuck = 1'b0;
  logic [19:0] flog[$];

  always @(posedge clk) begin
    if (reset) begin
      fbusy <= 1'b0;
      fcnt  <= 0;
    end else if (f_rstrb) begin
      fbusy <= 1'b1;
      fcnt  <= 3;
      faddr <= f_word_address;
      flog.push_back(f_word_address);
    end else if (fbusy && !stuck) begin
      if (fcnt <= 1) fbusy <= 1'b0;
      else           fcnt  <= fcnt - 1;
    end
  end

  assign f_rbusy = fbusy;
  assign f_rdata = word_of(faddr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] logat(input int i);
    return (i < flog.size()) ? flog[i] : 20'hFFFFF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rstrb_0 = 1'b0; rstrb_1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_free(input int p, input int budget, output int cyc);
    cyc = 0;
    while (((p == 0) ? rbusy_0 : rbusy_1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) chk($sformatf("wait_free_p%0d", p), 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int  cyc;
    int  n0, n1;
    bit  seen, fin;
    logic [19:0] ex;

    // Reset state, with a strobe held to show busy is masked during reset
    rstrb_0 = 1'b1; wa0 = 20'd1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rbusy0", rbusy_0, 0);
    chk("rst_rbusy1", rbusy_1, 0);
    chk("rst_frstrb", f_rstrb, 0);
    chk("rst_faddr", f_word_address, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata0", rdata_0, 0);
    rstrb_0 = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Single read on port 0
    flog.delete();
    rstrb_0 = 1'b1; wa0 = 20'h00005;
    #1 chk("t1_busy_comb", rbusy_0, 1);
    @(negedge clk);
    rstrb_0 = 1'b0;
    chk("t1_idle_nostrobe", f_rstrb, 0);
    @(negedge clk);
    chk("t1_frstrb", f_rstrb, 1);
    chk("t1_faddr", f_word_address, 20'h5);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (f_rbusy) seen = 1'b1;
      else if (seen) break;
    end
    chk("t1_fbusy_fell", {seen, f_rbusy}, 2'b10);
    chk("t1_busy_at_fall", rbusy_0, 1);
    @(negedge clk);
    chk("t1_busy_after", rbusy_0, 0);
    chk("t1_rdata0", rdata_0, 32'hDEADBEEF);
    chk("t1_rbusy1", rbusy_1, 0);
    chk("t1_rdata1", rdata_1, 0);
    chk("t1_nstrobes", flog.size(), 1);

    // Simultaneous strobes right after reset, then again
    do_reset();
    flog.delete();
    for (int r = 0; r < 2; r++) begin
      rstrb_0 = 1'b1; wa0 = 20'd3; rstrb_1 = 1'b1; wa1 = 20'd7;
      @(negedge clk);
      rstrb_0 = 1'b0; rstrb_1 = 1'b0;
      wait_free(0, 60, cyc);
      wait_free(1, 60, cyc);
      chk($sformatf("t2_first_r%0d", r), logat(2*r), 20'd3);
      chk($sformatf("t2_second_r%0d", r), logat(2*r+1), 20'd7);
    end
    chk("t2_rdata0", rdata_0, word_of(20'd3));
    chk("t2_rdata1", rdata_1, word_of(20'd7));

    // Both ports re-strobe whenever free: service must alternate
    n0 = 0; n1 = 0; fin = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rstrb_0 = 1'b0; rstrb_1 = 1'b0;
      #1;
      if (n0 == 3 && n1 == 3 && !rbusy_0 && !rbusy_1) begin
        fin = 1'b1;
        break;
      end
      if (n0 < 3 && !rbusy_0) begin rstrb_0 = 1'b1; wa0 = 20'(10 + n0); n0++; end
      if (n1 < 3 && !rbusy_1) begin rstrb_1 = 1'b1; wa1 = 20'(20 + n1); n1++; end
      @(negedge clk);
    end
    chk("t2_alt_finished", fin, 1);
    for (int k = 0; k < 6; k++) begin
      ex = (k % 2 == 0) ? 20'(10 + k/2) : 20'(20 + k/2);
      chk($sformatf("t2_alt_%0d", k), logat(4 + k), ex);
    end
    chk("t2_alt_rdata0", rdata_0, word_of(20'd12));
    chk("t2_alt_rdata1", rdata_1, word_of(20'd22));

    // Strobe while busy is ignored
    @(negedge clk);
    flog.delete();
    rstrb_0 = 1'b1; wa0 = 20'd13;
    @(negedge clk);
    rstrb_0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_busy", rbusy_0, 1);
    rstrb_0 = 1'b1; wa0 = 20'd9;
    @(negedge clk);
    rstrb_0 = 1'b0;
    wait_free(0, 60, cyc);
    repeat (6) @(negedge clk);
    chk("t3_nstrobes", flog.size(), 1);
    chk("t3_addr", logat(0), 20'd13);
    chk("t3_rdata0", rdata_0, word_of(20'd13));
    chk("t3_rbusy0", rbusy_0, 0);

    // Reset during WAIT aborts the read
    do_reset();
    flog.delete();
    rstrb_1 = 1'b1; wa1 = 20'd14;
    @(negedge clk);
    rstrb_1 = 1'b0;
    @(negedge clk);
    chk("t4_frstrb", f_rstrb, 1);
    repeat (2) @(negedge clk);
    chk("t4_busy_wait", rbusy_1, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_rst_rbusy1", rbusy_1, 0);
    chk("t4_rst_rbusy0", rbusy_0, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_rbusy1_after", rbusy_1, 0);
    chk("t4_rdata1", rdata_1, 0);
    chk("t4_rdata0", rdata_0, 0);
    chk("t4_nstrobes", flog.size(), 1);
    chk("t4_err", err, 0);

    // Flash stuck busy: watchdog fires, err is sticky
    flog.delete();
    stuck = 1'b1;
    rstrb_0 = 1'b1; wa0 = 20'd15;
    @(negedge clk);
    rstrb_0 = 1'b0;
    wait_free(0, 100, cyc);
    chk("t5_tmo_rdata", rdata_0, 32'hFFFFFFFF);
    chk("t5_err", err, 1);
    chk("t5_waited", (cyc >= 16), 1);
    stuck = 1'b0;
    repeat (6) @(negedge clk);
    rstrb_1 = 1'b1; wa1 = 20'd16;
    @(negedge clk);
    rstrb_1 = 1'b0;
    wait_free(1, 60, cyc);
    chk("t5_next_rdata", rdata_1, word_of(20'd16));
    chk("t5_err_sticky", err, 1);
    chk("t5_next_addr", logat(1), 20'd16);

    // Same address read twice
    @(negedge clk);
    flog.delete();
    rstrb_0 = 1'b1; wa0 = 20'd4;
    @(negedge clk);
    rstrb_0 = 1'b0;
    wait_free(0, 60, cyc);
    chk("t6_first_rdata", rdata_0, word_of(20'd4));
    @(negedge clk);
    rstrb_0 = 1'b1; wa0 = 20'd4;
    @(negedge clk);
    rstrb_0 = 1'b0;
`ifdef SPI_ARB_LASTWORD_CACHE_EN
    #1 chk("t6_hit_busy1", rbusy_0, 1);
    @(negedge clk);
    chk("t6_hit_busy2", rbusy_0, 0);
    chk("t6_hit_rdata", rdata_0, word_of(20'd4));
    repeat (4) @(negedge clk);
    chk("t6_nstrobes", flog.size(), 1);
`else
    wait_free(0, 60, cyc);
    chk("t6_rdata", rdata_0, word_of(20'd4));
    chk("t6_nstrobes", flog.size(), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
